// File: rtl/uart_boot_loader_pkg.sv
// Shared state encoding and memory geometry for the UART boot loader.
// The BRAM size and word-address width must match the soc memory map.
package uart_boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_H,
        ST_LEN_L,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         MEM_BYTES_DEF = 1024;
    localparam int         AW_DEF        = 9;

    function automatic logic is_busy(input state_t s);
        return !(s inside {ST_IDLE, ST_DONE, ST_ERR});
    endfunction

endpackage

// File: rtl/uart_boot_loader_timeout_cnt.sv
// Inter-byte watchdog: counts idle clocks while enabled, cleared by each byte,
// and flags expiry when the count reaches LIMIT-1 without a clear.
module boot_timeout_cnt #(
    parameter int LIMIT = 1000000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int            CW   = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d     = cnt_q;
        o_expired = 1'b0;
        if (!i_en || i_clr) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            // Saturate; the owner aborts on this cycle and drops the enable.
            o_expired = 1'b1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_boot_loader.sv
// Receives a framed program image (sync, 16-bit BE length, data, checksum) and
// writes it to BRAM via byte-lane strobes, releasing CPU reset on a good image.
module uart_boot_loader
    import uart_boot_loader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int         MEM_BYTES   = MEM_BYTES_DEF,
    parameter int         AW          = AW_DEF,
    parameter int         TIMEOUT_CYC = 1000000
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [7:0]    i_rx_data,
    input  logic          i_rx_valid,
    input  logic          i_rx_err,
    input  logic          i_reload,
    output logic [AW-1:0] o_mem_addr,
    output logic          o_mem_we_h,
    output logic          o_mem_we_l,
    output logic [7:0]    o_mem_din,
    output logic          o_cpu_rst,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err
);

    state_t        state_q, state_d;
    logic [15:0]   len_q, len_d;
    logic [15:0]   idx_q, idx_d;
    logic [7:0]    csum_q, csum_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    din_q, din_d;
    logic          we_h_q, we_h_d;
    logic          we_l_q, we_l_d;
    logic          cpu_rst_q, cpu_rst_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [7:0]    byte_sum;
    logic [15:0]   len_full;
    logic          expired;

    boot_timeout_cnt #(.LIMIT(TIMEOUT_CYC)) u_timeout (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clr     (i_rx_valid),
        .i_en      (is_busy(state_q)),
        .o_expired (expired)
    );

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        idx_d    = idx_q;
        csum_d   = csum_q;
        addr_d   = addr_q;
        din_d    = din_q;
        we_h_d   = 1'b0;
        we_l_d   = 1'b0;
        byte_sum = csum_q + i_rx_data;
        len_full = {len_q[15:8], i_rx_data};

        // Reload wins over everything, then aborts, then normal byte handling.
        if (i_reload) begin
            state_d = ST_IDLE;
            csum_d  = '0;
        end else if (is_busy(state_q) && (i_rx_err || expired)) begin
            state_d = ST_ERR;
        end else if (i_rx_valid) begin
            case (state_q)
                ST_IDLE, ST_ERR: begin
                    if (i_rx_data == SYNC_BYTE) begin
                        state_d = ST_LEN_H;
                        csum_d  = '0;
                    end
                end
                ST_LEN_H: begin
                    len_d[15:8] = i_rx_data;
                    csum_d      = byte_sum;
                    state_d     = ST_LEN_L;
                end
                ST_LEN_L: begin
                    len_d  = len_full;
                    csum_d = byte_sum;
                    idx_d  = '0;
                    if (len_full == 16'd0 || len_full > 16'(MEM_BYTES)) state_d = ST_ERR;
                    else                                                state_d = ST_DATA;
                end
                ST_DATA: begin
                    csum_d = byte_sum;
                    addr_d = idx_q[AW:1];
                    din_d  = i_rx_data;
                    we_h_d = !idx_q[0];
                    we_l_d = idx_q[0];
                    idx_d  = idx_q + 16'd1;
                    if (idx_q == len_q - 16'd1) state_d = ST_CSUM;
                end
                ST_CSUM: begin
                    csum_d  = byte_sum;
                    state_d = (byte_sum == 8'd0) ? ST_DONE : ST_ERR;
                end
                default: ;
            endcase
        end

        cpu_rst_d = (state_d != ST_DONE);
        done_d    = (state_d == ST_DONE);
        err_d     = (state_d == ST_ERR);
        busy_d    = is_busy(state_d);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            idx_q     <= '0;
            csum_q    <= '0;
            addr_q    <= '0;
            din_q     <= '0;
            we_h_q    <= 1'b0;
            we_l_q    <= 1'b0;
            cpu_rst_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            csum_q    <= csum_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            we_h_q    <= we_h_d;
            we_l_q    <= we_l_d;
            cpu_rst_q <= cpu_rst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign o_mem_addr = addr_q;
    assign o_mem_we_h = we_h_q;
    assign o_mem_we_l = we_l_q;
    assign o_mem_din  = din_q;
    assign o_cpu_rst  = cpu_rst_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: table of frames plus hand-built corner sequences.
module tb_uart_boot_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_err = 1'b0;
    logic       reload = 1'b0;
    logic [8:0] mem_addr;
    logic       we_h, we_l;
    logic [7:0] mem_din;
    logic       cpu_rst, busy, done, err;

    int checks = 0;
    int errors = 0;

    uart_boot_loader #(.TIMEOUT_CYC(16)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_rx_data  (rx_data),
        .i_rx_valid (rx_valid),
        .i_rx_err   (rx_err),
        .i_reload   (reload),
        .o_mem_addr (mem_addr),
        .o_mem_we_h (we_h),
        .o_mem_we_l (we_l),
        .o_mem_din  (mem_din),
        .o_cpu_rst  (cpu_rst),
        .o_busy     (busy),
        .o_done     (done),
        .o_err      (err)
    );

    always #5 clk = ~clk;

    // Write capture: strobes are registered, so the posedge sees the cycle just ended.
    logic [8:0] wr_addr [0:4095];
    logic [1:0] wr_lane [0:4095];
    logic [7:0] wr_din  [0:4095];
    int         wr_cnt = 0;

    always @(posedge clk) begin
        if (we_h || we_l) begin
            wr_addr[wr_cnt] <= mem_addr;
            wr_lane[wr_cnt] <= {we_h, we_l};
            wr_din[wr_cnt]  <= mem_din;
            wr_cnt          <= wr_cnt + 1;
        end
    end

    typedef struct {
        bit              pre_reload;
        int              nb;
        logic [0:7][7:0] b;
        int              doff;
        bit              exp_done;
        bit              exp_err;
        int              exp_nwr;
    } vec_t;

    vec_t vecs [0:7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_reload();
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    initial begin
        int          base;
        int          mism;
        logic [7:0]  s;
        logic [7:0]  d;
        logic        seen_err;

        vecs[0] = '{1'b0, 8, {8'hA5,8'h00,8'h04,8'h11,8'h22,8'h33,8'h44,8'h52}, 3, 1'b1, 1'b0, 4};
        vecs[1] = '{1'b1, 8, {8'hA5,8'h00,8'h04,8'h11,8'h22,8'h33,8'h44,8'h53}, 3, 1'b0, 1'b1, 4};
        vecs[2] = '{1'b0, 8, {8'hA5,8'h00,8'h04,8'h11,8'h22,8'h33,8'h44,8'h52}, 3, 1'b1, 1'b0, 4};
        vecs[3] = '{1'b1, 3, {8'hA5,8'h04,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00}, 3, 1'b0, 1'b1, 0};
        vecs[4] = '{1'b0, 3, {8'hA5,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 3, 1'b0, 1'b1, 0};
        vecs[5] = '{1'b0, 7, {8'hA5,8'h00,8'h03,8'hAA,8'hBB,8'hCC,8'hCC,8'h00}, 3, 1'b1, 1'b0, 3};
        vecs[6] = '{1'b1, 5, {8'hA5,8'h00,8'h01,8'h7E,8'h81,8'h00,8'h00,8'h00}, 3, 1'b1, 1'b0, 1};
        vecs[7] = '{1'b1, 7, {8'h33,8'hA5,8'h00,8'h02,8'h01,8'h02,8'hFB,8'h00}, 4, 1'b1, 1'b0, 2};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_outs", {done, err, busy, we_h, we_l}, 0);
        chk("rst_addr_din", {mem_addr, mem_din}, 0);
        rst_n = 1'b1;

        // Table-driven frames
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].pre_reload) pulse_reload();
            base = wr_cnt;
            for (int k = 0; k < vecs[i].nb; k++) send_byte(vecs[i].b[k]);
            chk($sformatf("v%0d_done", i), done, vecs[i].exp_done);
            chk($sformatf("v%0d_err", i), err, vecs[i].exp_err);
            chk($sformatf("v%0d_cpu_rst", i), cpu_rst, !vecs[i].exp_done);
            chk($sformatf("v%0d_busy", i), busy, 0);
            chk($sformatf("v%0d_nwr", i), wr_cnt - base, vecs[i].exp_nwr);
            for (int j = 0; j < vecs[i].exp_nwr; j++) begin
                chk($sformatf("v%0d_w%0d_addr", i, j), wr_addr[base + j], j >> 1);
                chk($sformatf("v%0d_w%0d_lane", i, j), wr_lane[base + j], (j % 2 == 0) ? 2'b10 : 2'b01);
                chk($sformatf("v%0d_w%0d_din", i, j), wr_din[base + j], vecs[i].b[vecs[i].doff + j]);
            end
        end

        // Strobe timing: single-cycle pulse the cycle after accept, addr/din hold
        pulse_reload();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h5A);
        chk("stb_we_h_now", {we_h, we_l}, 2'b10);
        chk("stb_addr_din", {mem_addr, mem_din}, {9'd0, 8'h5A});
        @(negedge clk);
        chk("stb_one_cycle", {we_h, we_l}, 2'b00);
        chk("stb_din_hold", mem_din, 8'h5A);
        send_byte(8'hC3); send_byte(8'hE1);
        chk("stb_frame_done", {done, cpu_rst}, 2'b10);

        // Reload from DONE
        pulse_reload();
        chk("reload_done_outs", {cpu_rst, done, err, busy}, 4'b1000);

        // Full 1 KB image, last write high address via low lane
        base = wr_cnt;
        s = 8'h04;
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h00);
        for (int k = 0; k < 1024; k++) begin
            d = k[7:0] ^ 8'h5A;
            s = s + d;
            send_byte(d);
        end
        send_byte(8'h00 - s);
        chk("big_done", {done, err, cpu_rst}, 3'b100);
        chk("big_nwr", wr_cnt - base, 1024);
        mism = 0;
        for (int k = 0; k < 1024; k++) begin
            d = k[7:0] ^ 8'h5A;
            if (wr_addr[base + k] !== 9'(k >> 1) || wr_din[base + k] !== d ||
                wr_lane[base + k] !== ((k % 2 == 0) ? 2'b10 : 2'b01)) mism++;
        end
        chk("big_writes", mism, 0);
        chk("big_last", {wr_addr[base + 1023], wr_lane[base + 1023]}, {9'd511, 2'b01});

        // DONE ignores rx traffic
        base = wr_cnt;
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01); send_byte(8'h77);
        @(negedge clk);
        chk("done_ignores", {done, busy, cpu_rst}, 3'b100);
        chk("done_no_writes", wr_cnt - base, 0);

        // Timeout: err exactly 16 clocks after the last byte
        pulse_reload();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02); send_byte(8'h11);
        seen_err = 1'b0;
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
            if (err || !busy) seen_err = 1'b1;
        end
        chk("tmo_not_early", seen_err, 0);
        @(negedge clk);
        chk("tmo_err_at_16", {err, busy, cpu_rst}, 3'b101);

        // rx_err mid-DATA aborts next cycle
        send_byte(8'hA5);
        chk("sync_clears_err", {err, busy}, 2'b01);
        send_byte(8'h00); send_byte(8'h04); send_byte(8'h11);
        @(negedge clk);
        rx_err = 1'b1;
        @(negedge clk);
        rx_err = 1'b0;
        chk("rxerr_abort", {err, busy, cpu_rst, done}, 4'b1010);

        // Reload coincident with a data byte drops it
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h04); send_byte(8'h11);
        @(negedge clk);
        base = wr_cnt;
        rx_data  = 8'h22;
        rx_valid = 1'b1;
        reload   = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        reload   = 1'b0;
        chk("reload_no_stb", {we_h, we_l}, 2'b00);
        chk("reload_outs", {cpu_rst, done, err, busy}, 4'b1000);
        @(negedge clk);
        chk("reload_no_wr", wr_cnt - base, 0);

        // Asynchronous reset mid-DATA
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h04); send_byte(8'h11); send_byte(8'h22);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cpu_rst", cpu_rst, 1);
        chk("arst_outs", {done, err, busy, we_h, we_l}, 0);
        chk("arst_addr_din", {mem_addr, mem_din}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) send_byte(vecs[0].b[k]);
        chk("post_arst_frame", {done, err, cpu_rst}, 3'b100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
